// File: rtl/mem_port_arbiter.sv
// Shares one byte-lane memory port between fetch and data: grant in IDLE, fixed-latency ACCESS, one-cycle RESP.
// Data wins conflicts unless fetch has lost STARVE_LIMIT conflicts in a row.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halted,
  input  logic                 if_req,
  input  logic [XLEN-1:0]      if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [XLEN-1:0]      if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [XLEN-1:0]      d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [XLEN-1:0]      d_rdata,
  output logic [XLEN-1:0]      mem_addr,
  output logic [0:3][7:0]      mem_data_in,
  input  logic [0:3][7:0]      mem_data_out,
  output logic                 mem_write_en,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] LAST_CNT   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic              own_if_q;
  logic [XLEN-1:0]   if_rdata_q;
  logic [XLEN-1:0]   d_rdata_q;

  logic              grant_ok;
  logic              fetch_wins;
  logic              capture;
  logic [31:0]       rd_word;

  // A request arriving together with reset must not be granted.
  always_comb begin
    grant_ok   = (state_q == S_IDLE) && !halted && !rst;
    fetch_wins = if_req && (!d_req || (starve_q == STARVE_MAX));
    if_gnt     = grant_ok && fetch_wins;
    d_gnt      = grant_ok && d_req && !fetch_wins;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (if_gnt || d_gnt) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end
        if (if_gnt) begin
          starve_d = '0;
        end else if (d_gnt && if_req && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + 4'd1;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capture      = (state_q == S_ACCESS) && (cnt_q == LAST_CNT) && !we_q;
    rd_word      = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
    mem_write_en = (state_q == S_ACCESS) && we_q && (cnt_q == 4'd0);
    busy         = (state_q != S_IDLE);
    if_rvalid    = (state_q == S_RESP) && own_if_q;
    d_rvalid     = (state_q == S_RESP) && !own_if_q;
    mem_addr     = addr_q;
    if_rdata     = if_rdata_q;
    d_rdata      = d_rdata_q;
    for (int i = 0; i < 4; i++) begin
      mem_data_in[i] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      own_if_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      if (if_gnt || d_gnt) begin
        addr_q   <= if_gnt ? if_addr : d_addr;
        wdata_q  <= d_wdata;
        we_q     <= d_gnt && d_we;
        own_if_q <= if_gnt;
      end
      if (capture && own_if_q)  if_rdata_q <= XLEN'(rd_word);
      if (capture && !own_if_q) d_rdata_q  <= XLEN'(rd_word);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, halted;
  logic             if_req, if_gnt, if_rvalid;
  logic [31:0]      if_addr, if_rdata;
  logic             d_req, d_we, d_gnt, d_rvalid;
  logic [31:0]      d_addr, d_wdata, d_rdata, mem_addr;
  logic [0:3][7:0]  mem_data_in, mem_data_out;
  logic             mem_write_en, busy;

  logic             if_req1, if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_write_en1, busy1;
  logic [31:0]      if_addr1, if_rdata1, d_rdata1, mem_addr1;
  logic [0:3][7:0]  mem_data_in1, mem_data_out1;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .busy(busy)
  );

  mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .halted(1'b0),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1),
    .mem_write_en(mem_write_en1), .busy(busy1)
  );

  // Memory contents as a pure function of address; 0x40 holds the load-test word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h1122_3344;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  always_comb begin
    logic [31:0] w0, w1;
    w0 = mem_word(mem_addr);
    w1 = mem_word(mem_addr1);
    for (int i = 0; i < 4; i++) begin
      mem_data_out[i]  = w0[8*i +: 8];
      mem_data_out1[i] = w1[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] fa, cur;
    logic        exp_f;

    rst = 1'b1; halted = 1'b0;
    if_req = 1'b0; if_addr = '0; if_req1 = 1'b0; if_addr1 = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = '0;
    step(); step();
    #1;
    chk("rst_no_gnt",  {31'b0, d_gnt}, 32'h0);
    chk("rst_busy",    {31'b0, busy}, 32'h0);
    chk("rst_addr",    mem_addr, 32'h0);
    chk("rst_lanes",   mem_data_in, 32'h0);
    chk("rst_if_rd",   if_rdata, 32'h0);
    chk("rst_d_rd",    d_rdata, 32'h0);
    chk("rst_we",      {31'b0, mem_write_en}, 32'h0);
    d_req = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Single load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #1 chk("load_gnt", {31'b0, d_gnt}, 32'h1);
    step(); d_req = 1'b0;
    #1 chk("load_busy_t1", {31'b0, busy}, 32'h1);
    chk("load_addr", mem_addr, 32'h40);
    chk("load_we_t1", {31'b0, mem_write_en}, 32'h0);
    step();
    chk("load_we_t2", {31'b0, mem_write_en}, 32'h0);
    chk("load_rv_t2", {31'b0, d_rvalid}, 32'h0);
    step();
    chk("load_rv_t3", {31'b0, d_rvalid}, 32'h1);
    chk("load_rdata", d_rdata, 32'h1122_3344);
    step();
    chk("load_rv_t4", {31'b0, d_rvalid}, 32'h0);
    chk("load_idle", {31'b0, busy}, 32'h0);

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
    #1 chk("st_gnt", {31'b0, d_gnt}, 32'h1);
    step(); d_req = 1'b0;
    #1 chk("st_we_t1", {31'b0, mem_write_en}, 32'h1);
    chk("st_addr", mem_addr, 32'h80);
    chk("st_lane0", {24'b0, mem_data_in[0]}, 32'hEF);
    chk("st_lane1", {24'b0, mem_data_in[1]}, 32'hBE);
    chk("st_lane2", {24'b0, mem_data_in[2]}, 32'hAD);
    chk("st_lane3", {24'b0, mem_data_in[3]}, 32'hDE);
    step();
    chk("st_we_t2", {31'b0, mem_write_en}, 32'h0);
    step();
    chk("st_rv_t3", {31'b0, d_rvalid}, 32'h1);
    chk("st_rdata_kept", d_rdata, 32'h1122_3344);
    step();
    chk("st_addr_hold", mem_addr, 32'h80);

    // Starvation: both requests held continuously
    fa = 32'h1000; if_addr = fa; if_req = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      exp_f = (k == 4) || (k == 9);
      #1;
      chk($sformatf("starve_if_gnt%0d", k), {31'b0, if_gnt}, {31'b0, exp_f});
      chk($sformatf("starve_d_gnt%0d", k),  {31'b0, d_gnt},  {31'b0, !exp_f});
      cur = fa;
      step();
      if (exp_f) begin
        fa = fa + 32'h10;
        if_addr = fa;
      end
      step(); step();
      #1;
      if (exp_f) begin
        chk($sformatf("starve_if_rv%0d", k), {31'b0, if_rvalid}, 32'h1);
        chk($sformatf("starve_if_rd%0d", k), if_rdata, mem_word(cur));
      end else begin
        chk($sformatf("starve_d_rv%0d", k), {31'b0, d_rvalid}, 32'h1);
        chk($sformatf("starve_d_rd%0d", k), d_rdata, mem_word(32'h200));
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Halt raised mid fetch
    if_req = 1'b1; if_addr = 32'h300;
    #1 chk("halt_gnt", {31'b0, if_gnt}, 32'h1);
    step(); halted = 1'b1;
    step(); step();
    chk("halt_if_rv", {31'b0, if_rvalid}, 32'h1);
    chk("halt_if_rd", if_rdata, mem_word(32'h300));
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("halt_no_gnt%0d", k), {31'b0, if_gnt}, 32'h0);
      chk($sformatf("halt_idle%0d", k), {31'b0, busy}, 32'h0);
    end
    halted = 1'b0;
    #1 chk("unhalt_gnt", {31'b0, if_gnt}, 32'h1);
    step(); if_req = 1'b0;
    step(); step(); step();
    chk("unhalt_idle", {31'b0, busy}, 32'h0);

    // Reset in the first access cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'h1234_5678;
    #1 chk("rstx_gnt", {31'b0, d_gnt}, 32'h1);
    step(); d_req = 1'b0; rst = 1'b1;
    #1 chk("rstx_we_t1", {31'b0, mem_write_en}, 32'h1);
    step(); rst = 1'b0;
    chk("rstx_we_t2", {31'b0, mem_write_en}, 32'h0);
    chk("rstx_busy", {31'b0, busy}, 32'h0);
    chk("rstx_addr", mem_addr, 32'h0);
    chk("rstx_lanes", mem_data_in, 32'h0);
    chk("rstx_d_rd", d_rdata, 32'h0);
    chk("rstx_if_rd", if_rdata, 32'h0);
    step();
    chk("rstx_no_rv_t3", {31'b0, d_rvalid}, 32'h0);
    step();
    chk("rstx_no_rv_t4", {31'b0, d_rvalid}, 32'h0);

    // Back-to-back fetch at MEM_LATENCY=1
    if_req1 = 1'b1; if_addr1 = 32'h500;
    #1 chk("l1_gnt_t0", {31'b0, if_gnt1}, 32'h1);
    step(); if_addr1 = 32'h504;
    #1 chk("l1_busy_t1", {31'b0, busy1}, 32'h1);
    chk("l1_gnt_t1", {31'b0, if_gnt1}, 32'h0);
    step();
    chk("l1_rv_t2", {31'b0, if_rvalid1}, 32'h1);
    chk("l1_rd_t2", if_rdata1, mem_word(32'h500));
    step();
    chk("l1_gnt_t3", {31'b0, if_gnt1}, 32'h1);
    chk("l1_busy_t3", {31'b0, busy1}, 32'h0);
    step(); if_req1 = 1'b0;
    #1 chk("l1_busy_t4", {31'b0, busy1}, 32'h1);
    step();
    chk("l1_rv_t5", {31'b0, if_rvalid1}, 32'h1);
    chk("l1_rd_t5", if_rdata1, mem_word(32'h504));
    step();
    chk("l1_rv_t6", {31'b0, if_rvalid1}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
